// File: rtl/fill_pkg.sv
// rtl/fill_pkg.sv - shared defaults and FSM state type for the row fill engine
package fill_pkg;

    localparam int FILL_X_W      = 10;
    localparam int FILL_Y_W      = 9;
    localparam int FILL_SCREEN_W = 640;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        MDONE,
        ROWWAIT,
        LOAD,
        FILL,
        FDONE
    } fill_state_t;

endpackage

// File: rtl/fill_span_stepper.sv
// rtl/fill_span_stepper.sv - row span x counter with end compare; FILL_CLIP_EN clamps the span to the screen
module fill_span_stepper
    import fill_pkg::*;
#(
    parameter int X_W      = FILL_X_W,
    parameter int SCREEN_W = FILL_SCREEN_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [X_W-1:0] span_x0,
    input  logic [X_W-1:0] span_x1,
    output logic [X_W-1:0] x,
    output logic           last,
    output logic           empty
);

`ifdef FILL_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    localparam logic [X_W-1:0] CLIP_MAX = X_W'(SCREEN_W - 1);

    logic [X_W-1:0] x_lo;
    logic [X_W-1:0] x_hi;
    logic [X_W-1:0] x_hi_eff;
    logic [X_W-1:0] lo_in;
    logic [X_W-1:0] hi_in;

    assign lo_in = (span_x0 < span_x1) ? span_x0 : span_x1;
    assign hi_in = (span_x0 < span_x1) ? span_x1 : span_x0;

    // The counter starts at x_lo as soon as the span is sampled, so LOAD just waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            x    <= '0;
            x_lo <= '0;
            x_hi <= '0;
        end else if (load) begin
            x    <= lo_in;
            x_lo <= lo_in;
            x_hi <= hi_in;
        end else if (step) begin
            x <= x + 1'b1;
        end
    end

    always_comb begin
        x_hi_eff = (CLIP_ON && (x_hi > CLIP_MAX)) ? CLIP_MAX : x_hi;
        empty    = CLIP_ON && (x_lo > CLIP_MAX);
        last     = (x == x_hi_eff);
    end

endmodule

// File: rtl/fill_row_engine.sv
// rtl/fill_row_engine.sv - triangle row fill sequencer emitting one pixel per accepted cycle (FILL_CLIP_EN enables screen clipping)
module fill_row_engine
    import fill_pkg::*;
#(
    parameter int X_W      = FILL_X_W,
    parameter int Y_W      = FILL_Y_W,
    parameter int SCREEN_W = FILL_SCREEN_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           math_start,
    input  logic           row_start,
    input  logic           fill_start,
    input  logic [Y_W-1:0] y_a,
    input  logic [Y_W-1:0] y_b,
    input  logic [7:0]     color_in,
    input  logic [X_W-1:0] span_x0,
    input  logic [X_W-1:0] span_x1,
    input  logic           pix_ready,
    output logic           math_done,
    output logic           fill_done,
    output logic           all_finish,
    output logic           pix_wr,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic [7:0]     pix_color
);

    fill_state_t    state;
    fill_state_t    state_next;
    logic [Y_W-1:0] y_lo;
    logic [Y_W-1:0] y_hi;
    logic [7:0]     color;
    logic [Y_W:0]   cur_y;
    logic           rows_done;
    logic           latch_math;
    logic           load_span;
    logic           step;
    logic [X_W-1:0] x;
    logic           last;
    logic           empty;

    fill_span_stepper #(
        .X_W      (X_W),
        .SCREEN_W (SCREEN_W)
    ) u_stepper (
        .clk     (clk),
        .rst     (rst),
        .load    (load_span),
        .step    (step),
        .span_x0 (span_x0),
        .span_x1 (span_x1),
        .x       (x),
        .last    (last),
        .empty   (empty)
    );

    // cur_y carries one extra bit so finishing the row at y = 2^Y_W-1 cannot wrap.
    assign rows_done = (cur_y > {1'b0, y_hi});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            y_lo  <= '0;
            y_hi  <= '0;
            color <= '0;
            cur_y <= '0;
        end else begin
            state <= state_next;
            if (latch_math) begin
                y_lo  <= (y_a < y_b) ? y_a : y_b;
                y_hi  <= (y_a < y_b) ? y_b : y_a;
                color <= color_in;
            end
            if (state == CALC) begin
                cur_y <= {1'b0, y_lo};
            end else if (state == FDONE) begin
                cur_y <= cur_y + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        math_done  = 1'b0;
        fill_done  = 1'b0;
        all_finish = 1'b0;
        pix_wr     = 1'b0;
        latch_math = 1'b0;
        load_span  = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (math_start) begin
                    latch_math = 1'b1;
                    state_next = CALC;
                end
            end
            CALC:  state_next = MDONE;
            MDONE: begin
                math_done  = 1'b1;
                state_next = ROWWAIT;
            end
            ROWWAIT: begin
                all_finish = rows_done;
                if (rows_done) begin
                    if (math_start) begin
                        latch_math = 1'b1;
                        state_next = CALC;
                    end
                end else if (row_start) begin
                    load_span  = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (fill_start) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (empty) begin
                    state_next = FDONE;
                end else begin
                    pix_wr = 1'b1;
                    if (pix_ready) begin
                        if (last) begin
                            state_next = FDONE;
                        end else begin
                            step = 1'b1;
                        end
                    end
                end
            end
            FDONE: begin
                fill_done  = 1'b1;
                state_next = ROWWAIT;
            end
            default: state_next = IDLE;
        endcase
    end

    assign pix_x     = pix_wr ? x : '0;
    assign pix_y     = pix_wr ? cur_y[Y_W-1:0] : '0;
    assign pix_color = pix_wr ? color : '0;

endmodule

// File: tb/tb_fill_row_engine.sv
// tb/tb_fill_row_engine.sv - self-checking bench for fill_row_engine (honours FILL_CLIP_EN)
module tb_fill_row_engine;

    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int SCREEN_W = 640;
`ifdef FILL_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           math_start;
    logic           row_start;
    logic           fill_start;
    logic [Y_W-1:0] y_a;
    logic [Y_W-1:0] y_b;
    logic [7:0]     color_in;
    logic [X_W-1:0] span_x0;
    logic [X_W-1:0] span_x1;
    logic           pix_ready;
    logic           math_done;
    logic           fill_done;
    logic           all_finish;
    logic           pix_wr;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic [7:0]     pix_color;

    int errors = 0;
    int checks = 0;
    int model_y;
    int model_hi;
    int model_col;

    typedef struct {
        bit          start;
        int          ya;
        int          yb;
        int          col;
        int          x0;
        int          x1;
        logic [31:0] pat;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[6];

    fill_row_engine #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .SCREEN_W (SCREEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .math_start (math_start),
        .row_start  (row_start),
        .fill_start (fill_start),
        .y_a        (y_a),
        .y_b        (y_b),
        .color_in   (color_in),
        .span_x0    (span_x0),
        .span_x1    (span_x1),
        .pix_ready  (pix_ready),
        .math_done  (math_done),
        .fill_done  (fill_done),
        .all_finish (all_finish),
        .pix_wr     (pix_wr),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_color  (pix_color)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_math_done"}, int'(math_done), 0);
        check({tag, "_fill_done"}, int'(fill_done), 0);
        check({tag, "_all_finish"}, int'(all_finish), 0);
        check({tag, "_pix_wr"}, int'(pix_wr), 0);
        check({tag, "_pix_x"}, int'(pix_x), 0);
        check({tag, "_pix_y"}, int'(pix_y), 0);
        check({tag, "_pix_color"}, int'(pix_color), 0);
    endtask

    task automatic do_math(input int ya, input int yb, input int col);
        y_a        = Y_W'(ya);
        y_b        = Y_W'(yb);
        color_in   = 8'(col);
        math_start = 1'b1;
        row_start  = 1'b0;
        fill_start = 1'b0;
        cyc();
        check("math_done_early", int'(math_done), 0);
        y_a      = Y_W'($urandom);
        y_b      = Y_W'($urandom);
        color_in = 8'($urandom);
        cyc();
        check("math_done_pulse", int'(math_done), 1);
        cyc();
        check("math_done_end", int'(math_done), 0);
        model_y   = (ya < yb) ? ya : yb;
        model_hi  = (ya < yb) ? yb : ya;
        model_col = col;
        check("math_all_finish", int'(all_finish), 0);
        cyc();
        math_start = 1'b0;
    endtask

    task automatic do_row(input int x0, input int x1, input logic [31:0] pat, output int npix);
        int lo;
        int hi;
        int cnt;
        int ex;
        int i;
        bit rdy;
        lo  = (x0 < x1) ? x0 : x1;
        hi  = (x0 < x1) ? x1 : x0;
        cnt = hi - lo + 1;
        if (CLIP) begin
            if (lo > SCREEN_W - 1) cnt = 0;
            else if (hi > SCREEN_W - 1) cnt = SCREEN_W - lo;
        end
        npix       = 0;
        row_start  = 1'b1;
        fill_start = 1'b1;
        span_x0    = X_W'(x0);
        span_x1    = X_W'(x1);
        cyc();
        span_x0    = X_W'($urandom);
        span_x1    = X_W'($urandom);
        fill_start = 1'b0;
        check("load_pix_wr", int'(pix_wr), 0);
        cyc();
        check("load_hold_pix_wr", int'(pix_wr), 0);
        fill_start = 1'b1;
        cyc();
        row_start  = 1'b0;
        fill_start = 1'b0;
        if (cnt == 0) begin
            check("empty_pix_wr", int'(pix_wr), 0);
            cyc();
        end else begin
            ex = lo;
            i  = 0;
            while (npix < cnt && i < 4000) begin
                rdy       = (pat == 32'h0) ? ($urandom_range(0, 3) != 0) : pat[i % 32];
                pix_ready = rdy;
                check("fill_pix_wr", int'(pix_wr), 1);
                check("fill_pix_x", int'(pix_x), ex);
                check("fill_pix_y", int'(pix_y), model_y);
                check("fill_pix_color", int'(pix_color), model_col);
                if (rdy) begin
                    ex++;
                    npix++;
                end
                cyc();
                i++;
            end
            if (npix < cnt) check("fill_timeout", npix, cnt);
        end
        pix_ready = 1'($urandom);
        check("fdone_fill_done", int'(fill_done), 1);
        check("fdone_pix_wr", int'(pix_wr), 0);
        cyc();
        model_y++;
        check("rowwait_fill_done", int'(fill_done), 0);
        check("rowwait_all_finish", int'(all_finish), (model_y > model_hi) ? 1 : 0);
    endtask

    task automatic finished_idle(input int n);
        for (int k = 0; k < n; k++) begin
            row_start  = 1'b1;
            fill_start = 1'($urandom);
            pix_ready  = 1'($urandom);
            cyc();
            check("finish_hold_all_finish", int'(all_finish), 1);
            check("finish_hold_pix_wr", int'(pix_wr), 0);
        end
        row_start  = 1'b0;
        fill_start = 1'b0;
    endtask

    initial begin
        int npix;
        int ya;
        int yb;
        int x0;
        int x1;

        tbl[0] = '{1'b1, 5, 3, 8'hA5, 12, 9, 32'hFFFF_FFFF, 4};
        tbl[1] = '{1'b0, 0, 0, 0, 20, 20, 32'hFFFF_FFFF, 1};
        tbl[2] = '{1'b0, 0, 0, 0, 0, 3, 32'hFFFF_FFF3, 4};
        tbl[3] = '{1'b1, 10, 11, 8'h3C, 700, 630, 32'hFFFF_FFFF, CLIP ? 10 : 71};
        tbl[4] = '{1'b0, 0, 0, 0, 650, 700, 32'h0, CLIP ? 0 : 51};
        tbl[5] = '{1'b1, 511, 511, 8'hFF, 1023, 1020, 32'h0, CLIP ? 0 : 4};

        rst        = 1'b1;
        math_start = 1'b0;
        row_start  = 1'b0;
        fill_start = 1'b0;
        y_a        = '0;
        y_b        = '0;
        color_in   = '0;
        span_x0    = '0;
        span_x1    = '0;
        pix_ready  = 1'b0;
        cyc();
        cyc();
        check_zero("reset");
        rst = 1'b0;
        cyc();

        for (int k = 0; k < 6; k++) begin
            if (tbl[k].start) begin
                if (k > 0) finished_idle(2);
                do_math(tbl[k].ya, tbl[k].yb, tbl[k].col);
            end
            do_row(tbl[k].x0, tbl[k].x1, tbl[k].pat, npix);
            check("tbl_pixel_count", npix, tbl[k].exp_cnt);
        end

        for (int t = 0; t < 15; t++) begin
            finished_idle(int'($urandom_range(1, 3)));
            ya = int'($urandom_range(0, 511));
            yb = ya + int'($urandom_range(0, 6)) - 3;
            if (yb < 0) yb = 0;
            if (yb > 511) yb = 511;
            do_math(ya, yb, int'($urandom_range(0, 255)));
            while (model_y <= model_hi) begin
                x0 = int'($urandom_range(0, 1023));
                x1 = x0 + int'($urandom_range(0, 20)) - 10;
                if (x1 < 0) x1 = 0;
                if (x1 > 1023) x1 = 1023;
                do_row(x0, x1, 32'h0, npix);
            end
        end

        do_math(20, 22, 8'h5A);
        row_start = 1'b1;
        span_x0   = 10'd100;
        span_x1   = 10'd110;
        cyc();
        row_start  = 1'b0;
        fill_start = 1'b1;
        cyc();
        fill_start = 1'b0;
        pix_ready  = 1'b1;
        check("rst_first_pix_x", int'(pix_x), 100);
        cyc();
        check("rst_second_pix_x", int'(pix_x), 101);
        check("rst_second_pix_wr", int'(pix_wr), 1);
        rst = 1'b1;
        cyc();
        check_zero("midfill_reset");
        rst        = 1'b0;
        row_start  = 1'b1;
        fill_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("post_reset_pix_wr", int'(pix_wr), 0);
            check("post_reset_all_finish", int'(all_finish), 0);
        end
        row_start  = 1'b0;
        fill_start = 1'b0;
        do_math(7, 7, 8'hC3);
        do_row(3, 5, 32'h0, npix);
        check("recover_pixel_count", npix, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
